// File: rtl/pe_issue_ctrl_pkg.sv
// rtl/pe_issue_ctrl_pkg.sv - shared PE constants and issue-controller state encoding
package pe_issue_ctrl_pkg;

    localparam int PE_TILE_BIT   = 10;
    localparam int PE_GRP_BIT    = 8;
    localparam int PE_FIFO_DEPTH = 1 << PE_TILE_BIT;
    // Depth of the PE core in_valid shift chain; the result collector keys off the same value.
    localparam int PE_DRAIN_CYC  = 11;

    typedef enum logic [2:0] {
        PE_IDLE  = 3'd0,
        PE_BIAS  = 3'd1,
        PE_RUN   = 3'd2,
        PE_GAP   = 3'd3,
        PE_DRAIN = 3'd4
    } pe_state_e;

endpackage

// File: rtl/pe_issue_ctrl.sv
// rtl/pe_issue_ctrl.sv - sequences bias load, tile/group beats and pipeline drain for one PE job
module pe_issue_ctrl
    import pe_issue_ctrl_pkg::*;
#(
    parameter int TILE_BIT  = PE_TILE_BIT,
    parameter int GRP_BIT   = PE_GRP_BIT,
    parameter int DRAIN_CYC = PE_DRAIN_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [TILE_BIT-1:0] cfg_tiles,
    input  logic [GRP_BIT-1:0]  cfg_groups,
    input  logic                cfg_pool,
    input  logic                data_valid,
    output logic                data_ready,
    output logic                in_valid,
    output logic                tofifo,
    output logic                fromfifo,
    output logic                bias_valid,
    output logic                poolop,
    output logic                busy,
    output logic                done
);

    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0]       DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [DW-1:0]       DRAIN_ONE  = DW'(1);
    localparam logic [TILE_BIT-1:0] TILE_ONE   = TILE_BIT'(1);
    localparam logic [GRP_BIT-1:0]  GRP_ONE    = GRP_BIT'(1);

    pe_state_e           state_q,  state_d;
    logic [TILE_BIT-1:0] tile_q,   tile_d;
    logic [TILE_BIT-1:0] tiles_q,  tiles_d;
    logic [GRP_BIT-1:0]  grp_q,    grp_d;
    logic [GRP_BIT-1:0]  groups_q, groups_d;
    logic                pool_q,   pool_d;
    logic [DW-1:0]       drain_q,  drain_d;

    logic cfg_ready_q,  cfg_ready_d;
    logic data_ready_q, data_ready_d;
    logic bias_valid_q, bias_valid_d;
    logic poolop_q,     poolop_d;
    logic busy_q,       busy_d;
    logic done_q,       done_d;

    logic beat;

    assign beat     = data_valid && data_ready_q;
    assign in_valid = beat;
    // Group 0 only writes, the final group only reads; a single-group job touches neither.
    assign tofifo   = beat && (grp_q != groups_q);
    assign fromfifo = beat && (grp_q != '0);

    assign cfg_ready  = cfg_ready_q;
    assign data_ready = data_ready_q;
    assign bias_valid = bias_valid_q;
    assign poolop     = poolop_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        state_d  = state_q;
        tile_d   = tile_q;
        tiles_d  = tiles_q;
        grp_d    = grp_q;
        groups_d = groups_q;
        pool_d   = pool_q;
        drain_d  = drain_q;

        case (state_q)
            PE_IDLE: begin
                if (cfg_valid && cfg_ready_q) begin
                    tiles_d  = cfg_tiles;
                    groups_d = cfg_groups;
                    pool_d   = cfg_pool;
                    tile_d   = '0;
                    grp_d    = '0;
                    state_d  = PE_BIAS;
                end
            end
            PE_BIAS: state_d = PE_RUN;
            PE_RUN: begin
                if (beat) begin
                    if (tile_q == tiles_q) begin
                        if (grp_q == groups_q) begin
                            drain_d = '0;
                            state_d = PE_DRAIN;
                        end else begin
                            tile_d  = '0;
                            grp_d   = grp_q + GRP_ONE;
                            state_d = PE_GAP;
                        end
                    end else begin
                        tile_d = tile_q + TILE_ONE;
                    end
                end
            end
            // One idle slot keeps a FIFO read in group g+1 behind its write in group g.
            PE_GAP: state_d = PE_RUN;
            PE_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = PE_IDLE;
                end else begin
                    drain_d = drain_q + DRAIN_ONE;
                end
            end
            default: state_d = PE_IDLE;
        endcase

        cfg_ready_d  = (state_d == PE_IDLE);
        data_ready_d = (state_d == PE_RUN);
        bias_valid_d = (state_d == PE_BIAS);
        busy_d       = (state_d != PE_IDLE);
        poolop_d     = (state_d != PE_IDLE) && pool_d;
        done_d       = (state_d == PE_DRAIN) && (drain_d == DRAIN_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PE_IDLE;
            tile_q       <= '0;
            tiles_q      <= '0;
            grp_q        <= '0;
            groups_q     <= '0;
            pool_q       <= 1'b0;
            drain_q      <= '0;
            cfg_ready_q  <= 1'b1;
            data_ready_q <= 1'b0;
            bias_valid_q <= 1'b0;
            poolop_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tile_q       <= tile_d;
            tiles_q      <= tiles_d;
            grp_q        <= grp_d;
            groups_q     <= groups_d;
            pool_q       <= pool_d;
            drain_q      <= drain_d;
            cfg_ready_q  <= cfg_ready_d;
            data_ready_q <= data_ready_d;
            bias_valid_q <= bias_valid_d;
            poolop_q     <= poolop_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_pe_issue_ctrl.sv
// tb/tb_pe_issue_ctrl.sv - scoreboard bench for pe_issue_ctrl with directed job vectors
module tb_pe_issue_ctrl;

    localparam int TB = 10;
    localparam int GB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_pool = 1'b0;
    logic          data_valid = 1'b0;
    logic [TB-1:0] cfg_tiles = '0;
    logic [GB-1:0] cfg_groups = '0;
    logic          cfg_ready, data_ready, in_valid, tofifo, fromfifo;
    logic          bias_valid, poolop, busy, done;

    pe_issue_ctrl #(.TILE_BIT(TB), .GRP_BIT(GB), .DRAIN_CYC(11)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_tiles  (cfg_tiles),
        .cfg_groups (cfg_groups),
        .cfg_pool   (cfg_pool),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .in_valid   (in_valid),
        .tofifo     (tofifo),
        .fromfifo   (fromfifo),
        .bias_valid (bias_valid),
        .poolop     (poolop),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic tf;
        logic ff;
        logic pool;
        int   off;
    } beat_t;

    beat_t exp_beat_q[$];
    int    exp_done_q[$];
    int    exp_bias_q[$];

    int n_vec = 0;
    int n_err = 0;
    int acc_cyc = 0;
    int n_acc = 0;
    int n_done = 0;
    int last_done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Offsets are cycles after the cycle in which the descriptor was accepted.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_valid && cfg_ready) begin
                acc_cyc = cyc;
                n_acc++;
            end
            if (bias_valid) begin
                if (exp_bias_q.size() == 0) flag_unexpected("bias_valid");
                else check("bias_offset", cyc - acc_cyc, exp_bias_q.pop_front());
            end
            if (in_valid) begin
                if (exp_beat_q.size() == 0) flag_unexpected("in_valid");
                else begin
                    beat_t b;
                    b = exp_beat_q.pop_front();
                    check("beat_offset", cyc - acc_cyc, b.off);
                    check("tofifo", tofifo, b.tf);
                    check("fromfifo", fromfifo, b.ff);
                    check("poolop", poolop, b.pool);
                end
            end else begin
                if (tofifo || fromfifo) flag_unexpected("fifo_flag_without_in_valid");
            end
            if (done) begin
                if (exp_done_q.size() == 0) flag_unexpected("done");
                else check("done_offset", cyc - acc_cyc, exp_done_q.pop_front());
                n_done++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic push_beat(input logic tf, input logic ff, input logic pool, input int off);
        beat_t b;
        b.tf = tf;
        b.ff = ff;
        b.pool = pool;
        b.off = off;
        exp_beat_q.push_back(b);
    endtask

    task automatic accept(input int tiles, input int groups, input logic pool);
        int k;
        cfg_tiles  = tiles[TB-1:0];
        cfg_groups = groups[GB-1:0];
        cfg_pool   = pool;
        cfg_valid  = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cfg_ready) break;
        end
        check("cfg_ready_wait", k < 200, 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 200; k++) begin
            if (n_done >= target) break;
            @(posedge clk);
        end
        check("done_seen", n_done >= target, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, done1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {in_valid, data_ready, tofifo, fromfifo, bias_valid, poolop, busy, done}, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cfg_ready", cfg_ready, 1);
        check("idle_busy", busy, 0);
        @(posedge clk);
        #1;

        // 4 tiles, single group
        data_valid = 1'b1;
        exp_bias_q.push_back(1);
        push_beat(0, 0, 0, 2); push_beat(0, 0, 0, 3); push_beat(0, 0, 0, 4); push_beat(0, 0, 0, 5);
        exp_done_q.push_back(16);
        accept(3, 0, 0);
        wait_done(1);

        // 2 tiles, 3 groups, pooling on
        exp_bias_q.push_back(1);
        push_beat(1, 0, 1, 2); push_beat(1, 0, 1, 3);
        push_beat(1, 1, 1, 5); push_beat(1, 1, 1, 6);
        push_beat(0, 1, 1, 8); push_beat(0, 1, 1, 9);
        exp_done_q.push_back(20);
        accept(1, 2, 1);
        wait_done(2);

        // single tile, 2 groups: gap separates write and read of the same entry
        exp_bias_q.push_back(1);
        push_beat(1, 0, 0, 2); push_beat(0, 1, 0, 4);
        exp_done_q.push_back(15);
        accept(0, 1, 0);
        wait_done(3);

        // data_valid 1,0,0,1 in RUN on a 2-tile job
        data_valid = 1'b0;
        exp_bias_q.push_back(1);
        push_beat(0, 0, 1, 2); push_beat(0, 0, 1, 5);
        exp_done_q.push_back(16);
        accept(1, 0, 1);
        @(posedge clk); #1; data_valid = 1'b1;
        @(posedge clk); #1; data_valid = 1'b0;
        @(posedge clk); #1;
        check("stall_busy", busy, 1);
        @(posedge clk); #1; data_valid = 1'b1;
        @(posedge clk); #1; data_valid = 1'b0;
        wait_done(4);

        // reset during third beat of a 4-tile job
        data_valid = 1'b1;
        exp_bias_q.push_back(1);
        push_beat(0, 0, 1, 2); push_beat(0, 0, 1, 3);
        accept(3, 0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midjob_rst_outputs", {in_valid, data_ready, tofifo, fromfifo, bias_valid, poolop, busy, done}, 0);
        check("midjob_rst_cfg_ready", cfg_ready, 1);
        check("midjob_beats_left", exp_beat_q.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cfg_ready", cfg_ready, 1);
        check("post_rst_busy", busy, 0);
        @(posedge clk); #1;
        exp_bias_q.push_back(1);
        push_beat(0, 0, 0, 2); push_beat(0, 0, 0, 3); push_beat(0, 0, 0, 4); push_beat(0, 0, 0, 5);
        exp_done_q.push_back(16);
        accept(3, 0, 0);
        wait_done(5);

        // cfg_valid held high across two back-to-back jobs
        exp_bias_q.push_back(1);
        push_beat(0, 0, 1, 2);
        exp_done_q.push_back(13);
        exp_bias_q.push_back(1);
        push_beat(1, 0, 0, 2); push_beat(1, 0, 0, 3);
        push_beat(0, 1, 0, 5); push_beat(0, 1, 0, 6);
        exp_done_q.push_back(17);
        acc0 = n_acc;
        accept(0, 0, 1);
        cfg_tiles  = 1;
        cfg_groups = 1;
        cfg_pool   = 1'b0;
        cfg_valid  = 1'b1;
        wait_done(6);
        done1 = last_done_cyc;
        check("held_cfg_single_accept", n_acc - acc0, 1);
        #1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        wait_done(7);
        check("b2b_accept_gap", acc_cyc - done1, 1);
        check("b2b_accept_count", n_acc - acc0, 2);

        repeat (3) @(posedge clk);
        check("beats_left", exp_beat_q.size(), 0);
        check("dones_left", exp_done_q.size(), 0);
        check("bias_left", exp_bias_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
